// File: rtl/fp_div_pkg.sv
// Shared widths, constants, special-case classes and pipeline record for the binary32 divider.
// The div_by_zero field exists only when FP_DIV_FLAGS_EN is defined.
package fp_div_pkg;

    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam int BIAS       = 127;
    localparam int LATENCY    = 28;
    localparam int DIV_STAGES = 26;
    localparam int REM_W      = FRAC_W + 2;
    localparam int Q_W        = DIV_STAGES;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // ZERO is encoded as 0 so that a cleared pipeline register emits +0.
    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_INF    = 2'd2,
        CLS_QNAN   = 2'd3
    } fp_class_t;

    typedef struct packed {
        logic                    sign;
        logic signed [EXP_W+1:0] exponent;
        logic [REM_W-1:0]        divisor;
        logic [REM_W-1:0]        remainder;
        logic [Q_W-1:0]          quotient;
        fp_class_t               cls;
`ifdef FP_DIV_FLAGS_EN
        logic                    div_by_zero;
`endif
    } div_stage_t;

    // Subnormal operands (exponent field 0) are flushed to zero here.
    function automatic fp_class_t classify(input logic [31:0] a, input logic [31:0] b);
        logic a_zero, b_zero, a_max, b_max, a_nan, b_nan, a_inf, b_inf;
        a_zero = (a[EXP_W+FRAC_W-1:FRAC_W] == '0);
        b_zero = (b[EXP_W+FRAC_W-1:FRAC_W] == '0);
        a_max  = (&a[EXP_W+FRAC_W-1:FRAC_W]);
        b_max  = (&b[EXP_W+FRAC_W-1:FRAC_W]);
        a_nan  = a_max && (a[FRAC_W-1:0] != '0);
        b_nan  = b_max && (b[FRAC_W-1:0] != '0);
        a_inf  = a_max && (a[FRAC_W-1:0] == '0);
        b_inf  = b_max && (b[FRAC_W-1:0] == '0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            return CLS_QNAN;
        else if (a_inf || b_zero)
            return CLS_INF;
        else if (a_zero || b_inf)
            return CLS_ZERO;
        else
            return CLS_NORMAL;
    endfunction

`ifdef FP_DIV_FLAGS_EN
    function automatic logic is_div_by_zero(input logic [31:0] a, input logic [31:0] b);
        return (b[EXP_W+FRAC_W-1:FRAC_W] == '0) &&
               (a[EXP_W+FRAC_W-1:FRAC_W] != '0) &&
               !(&a[EXP_W+FRAC_W-1:FRAC_W]);
    endfunction
`endif

endpackage

// File: rtl/fp_div_stage.sv
// One restoring-division iteration: shift the remainder, trial-subtract the divisor,
// and drop the resulting quotient bit into position BIT.
module fp_div_stage
    import fp_div_pkg::*;
#(
    parameter int BIT = Q_W - 1
) (
    input  logic [REM_W-1:0] divisor,
    input  logic [REM_W-1:0] rem_in,
    input  logic [Q_W-1:0]   quo_in,
    output logic [REM_W-1:0] rem_out,
    output logic [Q_W-1:0]   quo_out
);

    logic [REM_W:0] shifted;
    logic           take;

    // The remainder always stays below the divisor, so the shifted value fits one extra bit.
    always_comb begin
        shifted      = {rem_in, 1'b0};
        take         = (shifted >= {1'b0, divisor});
        rem_out      = take ? REM_W'(shifted - {1'b0, divisor}) : shifted[REM_W-1:0];
        quo_out      = quo_in;
        quo_out[BIT] = take;
    end

endmodule

// File: rtl/floating_division.sv
// Fully pipelined binary32 divider, 28-clock latency, one operation per clock.
// Define FP_DIV_FLAGS_EN to add the flags port {invalid, div_by_zero, overflow, underflow}.
module floating_division
    import fp_div_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
`ifdef FP_DIV_FLAGS_EN
    output logic [3:0]  flags,
`endif
    output logic [31:0] result
);

    div_stage_t       unpacked;
    div_stage_t       pipe [0:DIV_STAGES];
    logic [REM_W-1:0] rem_next [1:DIV_STAGES];
    logic [Q_W-1:0]   quo_next [1:DIV_STAGES];

    // The divisor is held pre-doubled so the first iteration yields the integer quotient bit.
    always_comb begin
        unpacked           = '0;
        unpacked.sign      = input_a[31] ^ input_b[31];
        unpacked.exponent  = 10'(input_a[30:23]) - 10'(input_b[30:23]) + 10'(BIAS);
        unpacked.divisor   = {1'b1, input_b[FRAC_W-1:0], 1'b0};
        unpacked.remainder = {2'b01, input_a[FRAC_W-1:0]};
        unpacked.cls       = classify(input_a, input_b);
`ifdef FP_DIV_FLAGS_EN
        unpacked.div_by_zero = is_div_by_zero(input_a, input_b);
`endif
    end

    for (genvar k = 1; k <= DIV_STAGES; k++) begin : g_div
        fp_div_stage #(.BIT(Q_W - k)) u_stage (
            .divisor (pipe[k-1].divisor),
            .rem_in  (pipe[k-1].remainder),
            .quo_in  (pipe[k-1].quotient),
            .rem_out (rem_next[k]),
            .quo_out (quo_next[k])
        );
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int k = 0; k <= DIV_STAGES; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= unpacked;
            for (int k = 1; k <= DIV_STAGES; k++) begin
                pipe[k]           <= pipe[k-1];
                pipe[k].remainder <= rem_next[k];
                pipe[k].quotient  <= quo_next[k];
            end
        end
    end

    logic [Q_W-1:0]          q;
    logic [FRAC_W-1:0]       frac;
    logic                    guard, sticky, round_up, ovf, unf;
    logic [FRAC_W:0]         frac_sum;
    logic signed [EXP_W+1:0] exp_adj, exp_fin;
    logic [31:0]             norm_value;
    logic [31:0]             norm_result;

    // Normalize to 1.f, round to nearest even, then resolve specials and range limits.
    always_comb begin
        q = pipe[DIV_STAGES].quotient;
        if (q[Q_W-1]) begin
            frac    = q[Q_W-2:2];
            guard   = q[1];
            sticky  = q[0] | (|pipe[DIV_STAGES].remainder);
            exp_adj = pipe[DIV_STAGES].exponent;
        end else begin
            frac    = q[Q_W-3:1];
            guard   = q[0];
            sticky  = |pipe[DIV_STAGES].remainder;
            exp_adj = pipe[DIV_STAGES].exponent - 10'sd1;
        end
        round_up = guard & (sticky | frac[0]);
        frac_sum = {1'b0, frac} + 24'(round_up);
        exp_fin  = exp_adj + 10'(frac_sum[FRAC_W]);
        ovf      = (exp_fin >= 10'sd255);
        unf      = (exp_fin <= 10'sd0);
        case (pipe[DIV_STAGES].cls)
            CLS_QNAN: norm_value = QNAN;
            CLS_INF:  norm_value = {pipe[DIV_STAGES].sign, 8'hFF, 23'h0};
            CLS_ZERO: norm_value = {pipe[DIV_STAGES].sign, 31'h0};
            default: begin
                if (ovf)
                    norm_value = {pipe[DIV_STAGES].sign, 8'hFF, 23'h0};
                else if (unf)
                    norm_value = {pipe[DIV_STAGES].sign, 31'h0};
                else
                    norm_value = {pipe[DIV_STAGES].sign, exp_fin[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            norm_result <= '0;
            result      <= '0;
        end else begin
            norm_result <= norm_value;
            result      <= norm_result;
        end
    end

`ifdef FP_DIV_FLAGS_EN
    logic [3:0] norm_flags;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            norm_flags <= '0;
            flags      <= '0;
        end else begin
            norm_flags <= {pipe[DIV_STAGES].cls == CLS_QNAN,
                           pipe[DIV_STAGES].div_by_zero,
                           (pipe[DIV_STAGES].cls == CLS_NORMAL) && ovf,
                           (pipe[DIV_STAGES].cls == CLS_NORMAL) && unf};
            flags      <= norm_flags;
        end
    end
`endif

endmodule

// File: tb/tb_floating_division.sv
// Directed self-checking bench for floating_division: reset, latency, rounding,
// special cases, range limits, back-to-back streaming and mid-stream reset.
module tb_floating_division;
    import fp_div_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] input_a, input_b;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    logic [31:0] vec_a[$], vec_b[$], vec_exp[$];
    string       vec_tag[$];

    floating_division dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .input_a (input_a),
        .input_b (input_b),
        .result  (result)
    );

    always #5 Clk = ~Clk;

    task automatic next_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b);
        input_a = a;
        input_b = b;
    endtask

    task automatic check_output(input string tag, input logic [31:0] expected);
        checks++;
        assert (result === expected) else begin
            errors++;
            $error("[TB] FAIL %s: result=%h expected=%h", tag, result, expected);
        end
    endtask

    // Exact binary32 encoding of a small integer (below 2^24).
    function automatic logic [31:0] int_to_fp(input int unsigned v, input logic s);
        int p;
        int unsigned shifted;
        if (v == 0) return {s, 31'h0};
        p = 0;
        for (int i = 0; i < 24; i++) if (v[i]) p = i;
        shifted = v << (23 - p);
        return {s, 8'(127 + p), shifted[22:0]};
    endfunction

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e, input string tag);
        vec_a.push_back(a);
        vec_b.push_back(b);
        vec_exp.push_back(e);
        vec_tag.push_back(tag);
    endtask

    // Feeds queued vectors on consecutive clocks and checks each LATENCY clocks later.
    task automatic run_stream();
        int n;
        n = vec_a.size();
        for (int c = 0; c < n + LATENCY; c++) begin
            if (c < n) apply_stimulus(vec_a[c], vec_b[c]);
            else       apply_stimulus(32'h0, 32'h3F80_0000);
            next_edge();
            if (c >= LATENCY) check_output(vec_tag[c-LATENCY], vec_exp[c-LATENCY]);
        end
        vec_a.delete();
        vec_b.delete();
        vec_exp.delete();
        vec_tag.delete();
    endtask

    initial begin
        Rst = 1'b1;
        apply_stimulus(32'h0, 32'h0);
        next_edge();
        check_output("reset_hold0", 32'h0);
        next_edge();
        check_output("reset_hold1", 32'h0);

        Rst = 1'b0;
        apply_stimulus(32'h4380_2148, 32'h41CA_0000);
        for (int i = 0; i <= LATENCY; i++) begin
            next_edge();
            if (i == 0) apply_stimulus(32'h0, 32'h3F80_0000);
            if (i < LATENCY) check_output("startup_zero", 32'h0);
            else             check_output("nominal_rne", 32'h4122_61F1);
        end

        add_vec(32'h40C0_0000, 32'hC000_0000, 32'hC040_0000, "six_div_neg_two");
        add_vec(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, "one_third");
        add_vec(32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, "two_thirds");
        add_vec(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, "one_div_zero");
        add_vec(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, "neg_one_div_zero");
        add_vec(32'h3FC0_0000, 32'h8000_0000, 32'hFF80_0000, "div_neg_zero");
        add_vec(32'h0000_0000, 32'h0000_0000, QNAN,          "zero_div_zero");
        add_vec(32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, "zero_div_five");
        add_vec(32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, "neg_zero_div_five");
        add_vec(32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, "inf_div_two");
        add_vec(32'h4040_0000, 32'h7F80_0000, 32'h0000_0000, "three_div_inf");
        add_vec(32'h7F80_0000, 32'hFF80_0000, QNAN,          "inf_div_inf");
        add_vec(32'h7FC0_0000, 32'h3F80_0000, QNAN,          "nan_operand");
        add_vec(32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, "subnormal_ftz");
        add_vec(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, "overflow");
        add_vec(32'h0080_0000, 32'h4100_0000, 32'h0000_0000, "underflow");
        run_stream();

        for (int i = 0; i < 30; i++) begin
            int unsigned n, m;
            logic s;
            n = i + 1;
            m = (i % 7) + 3;
            s = i[0];
            add_vec(int_to_fp(n * m, s), int_to_fp(m, 1'b0), int_to_fp(n, s), "back_to_back");
        end
        run_stream();

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(int_to_fp((i + 2) * 5, 1'b0), int_to_fp(5, 1'b0));
            next_edge();
        end
        Rst = 1'b1;
        apply_stimulus(32'h0, 32'h3F80_0000);
        next_edge();
        check_output("mid_reset", 32'h0);
        Rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            next_edge();
            check_output("post_reset_no_stale", 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
